seq_mult_booth: RTL and testbench
=================================

SEQ_MULT_BOOTH -- requirements
Module: seq_mult_booth

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have ports a, b  input  N each  multiplicand and multiplier; sampled with start.
REQ-007 SHALL have port m  output  N  high half of the 2N-bit product.
REQ-008 SHALL have port r  output  N  low half of the 2N-bit product.
REQ-009 SHALL have port valid  output  1  one-cycle pulse; m, r, ovf are new in this cycle.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port ovf  output  1  product not representable in N bits under the active mode.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE, start=1 SHALL latch a, b, signed_mode, load step counter with N+1, and go to CALC.
REQ-014 Operands SHALL be extended to N+1 bits: sign-extended if signed_mode=1, zero-extended otherwise.
REQ-015 CALC SHALL do one radix-2 Booth step per cycle (add/sub/none on multiplier bit pair, then arithmetic shift right), decrementing the counter.
REQ-016 CALC SHALL go to DONE on the cycle the counter reaches 0; CALC lasts exactly N+1 cycles.
REQ-017 DONE SHALL register m = product[2N-1:N], r = product[N-1:0], assert valid for that one cycle, and return to IDLE.
REQ-018 Latency: start sampled at edge k SHALL give valid=1 in the cycle after edge k+N+2.
REQ-019 busy SHALL be 1 in IDLE-to-CALC and all CALC cycles, and 0 in IDLE and DONE.
REQ-020 start=1 in DONE SHALL be accepted (back-to-back) and go directly to CALC; valid still pulses for the finishing result.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight or on latched operands.
REQ-022 m, r, ovf SHALL hold their last value outside DONE; input changes during CALC SHALL not affect the result.
REQ-023 ovf, signed: SHALL be 1 iff m differs from N copies of r[N-1]; unsigned: SHALL be 1 iff m != 0.
REQ-024 Most-negative operands (e.g. -2^(N-1) x -2^(N-1)) SHALL give the exact 2N-bit result, with no wrap inside the accumulator.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, m=0, r=0, valid=0, busy=0, ovf=0, counter=0, independent of clk.
REQ-026 Reset asserted during CALC SHALL abort the operation with no valid pulse; the first start after release SHALL behave as from power-up.
REQ-027 start SHALL be ignored while rst=0; the first sampling edge is the first rising clk with rst=1.

Verification (N=5 unless noted)
REQ-028 Signed a=11010(-6), b=00111(7) -> 7 cycles after start: valid=1, m=11110(-2), r=10110(-10), ovf=1; busy high for the 6 cycles before.
REQ-029 Unsigned, same bits (26x7) -> m=00101, r=10110, ovf=1; signed 00101x00011 -> m=00000, r=01111, ovf=0.
REQ-030 Signed 10000x10000 (-16x-16) -> m=01000, r=00000, ovf=1; signed 00101x11101 -> m=11111, r=10001(-15), ovf=0.
REQ-031 start pulsed mid-CALC with different a/b -> ignored; the original result emerges on time; start held in DONE -> next valid 7 cycles later.
REQ-032 rst=0 for one mid-CALC half-cycle -> outputs 0 immediately, no valid; a new start completes normally.
REQ-033 Randomised sweep, N=8, both modes -> every {m,r} equals the reference a*b; ovf matches REQ-023.

Source files
------------

// File: rtl/seq_mult_booth.sv
// Sequential radix-2 Booth multiplier for signed or unsigned N-bit operands.
// Produces a 2N-bit product split into m/r, plus an overflow flag, N+2 cycles after start.
module seq_mult_booth #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] m,
  output logic [N-1:0] r,
  output logic         valid,
  output logic         busy,
  output logic         ovf
);

  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] STEPS = CW'(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [CW-1:0]  count_reg;
  logic [N+1:0]   mcand_reg;
  logic [N+1:0]   hi_reg;
  logic [N:0]     lo_reg;
  logic           q1_reg;
  logic           mode_reg;
  logic [N-1:0]   m_reg;
  logic [N-1:0]   r_reg;
  logic           valid_reg;
  logic           ovf_reg;
  logic           accept;
  logic [N+1:0]   sum_hi;
  logic [2*N-1:0] prod;
  logic [N-1:0]   ovf_bits;
  logic           unused_hi;

  // New work is taken whenever the engine is not mid-calculation (IDLE or DONE).
  assign accept = start && (state_reg != CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count_reg == CW'(1)) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == CALC);
  end

  // Accumulator carries one guard bit above the N+1-bit multiplicand so the
  // most-negative operand pair cannot wrap.
  always_comb begin
    sum_hi = hi_reg;
    case ({lo_reg[0], q1_reg})
      2'b01:   sum_hi = hi_reg + mcand_reg;
      2'b10:   sum_hi = hi_reg - mcand_reg;
      default: sum_hi = hi_reg;
    endcase
  end

  assign prod = {hi_reg[N-2:0], lo_reg};

  // Overflow: high half must be a pure extension of the low half.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ovf
      assign ovf_bits[gi] = prod[N+gi] ^ (mode_reg & prod[N-1]);
    end
  endgenerate

  assign unused_hi = ^hi_reg[N+1:N-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      q1_reg    <= 1'b0;
      mode_reg  <= 1'b0;
      m_reg     <= '0;
      r_reg     <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == DONE) begin
        m_reg     <= prod[2*N-1:N];
        r_reg     <= prod[N-1:0];
        ovf_reg   <= |ovf_bits;
        valid_reg <= 1'b1;
      end
      if (accept) begin
        mode_reg  <= signed_mode;
        mcand_reg <= {{2{signed_mode & a[N-1]}}, a};
        hi_reg    <= '0;
        lo_reg    <= {signed_mode & b[N-1], b};
        q1_reg    <= 1'b0;
        count_reg <= STEPS;
      end else if (state_reg == CALC) begin
        hi_reg    <= {sum_hi[N+1], sum_hi[N+1:1]};
        lo_reg    <= {sum_hi[0], lo_reg[N:1]};
        q1_reg    <= lo_reg[0];
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign m     = m_reg;
  assign r     = r_reg;
  assign valid = valid_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_seq_mult_booth.sv
// Bench for seq_mult_booth: directed N=5 vectors with exact timing, plus a
// randomised N=8 sweep against an arithmetic reference model.
module tb_seq_mult_booth;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start5, sm5;
  logic [4:0] a5, b5, m5, r5;
  logic       valid5, busy5, ovf5;
  logic       start8, sm8;
  logic [7:0] a8, b8, m8, r8;
  logic       valid8, busy8, ovf8;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_booth #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5), .a(a5), .b(b5),
    .m(m5), .r(r5), .valid(valid5), .busy(busy5), .ovf(ovf5)
  );

  seq_mult_booth #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .m(m8), .r(r8), .valid(valid8), .busy(busy8), .ovf(ovf8)
  );

  logic [4:0] dir_a [5] = '{5'b11010, 5'b11010, 5'b00101, 5'b10000, 5'b00101};
  logic [4:0] dir_b [5] = '{5'b00111, 5'b00111, 5'b00011, 5'b10000, 5'b11101};
  logic       dir_s [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0] dir_m [5] = '{5'b11110, 5'b00101, 5'b00000, 5'b01000, 5'b11111};
  logic [4:0] dir_r [5] = '{5'b10110, 5'b10110, 5'b01111, 5'b00000, 5'b10001};
  logic       dir_o [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  // Reference: interpret operands as integers, multiply, range-check.
  function automatic longint ref_product(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic sm);
    longint x, y;
    x = longint'(av);
    y = longint'(bv);
    if (sm && av[w-1]) x = x - (longint'(1) << w);
    if (sm && bv[w-1]) y = y - (longint'(1) << w);
    return x * y;
  endfunction

  function automatic logic ref_ovf(input int w, input longint p, input logic sm);
    if (sm) return (p < -(longint'(1) << (w - 1))) || (p >= (longint'(1) << (w - 1)));
    return p >= (longint'(1) << w);
  endfunction

  // Returns at the falling edge right after the start-sampling edge.
  task automatic launch5(input logic [4:0] av, input logic [4:0] bv, input logic sm);
    @(negedge clk);
    a5 = av; b5 = bv; sm5 = sm; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
  endtask

  task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    @(negedge clk);
    a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start5 = 1'b1; a5 = 5'b11111; b5 = 5'b11111; sm5 = 1'b1;
    start8 = 1'b1; a8 = 8'hff; b8 = 8'hff; sm8 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m5, r5, valid5, busy5, ovf5} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset5: got m=%b r=%b v=%b busy=%b ovf=%b, expected all zero", m5, r5, valid5, busy5, ovf5);
    end
    n_checks++;
    if ({m8, r8, valid8, busy8, ovf8} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset8: got m=%h r=%h v=%b busy=%b ovf=%b, expected all zero", m8, r8, valid8, busy8, ovf8);
    end
    start5 = 1'b0; start8 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy5 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b expected 0", busy5);
    end
    $display("txn reset: outputs checked during and after reset");
  endtask

  task automatic test_directed;
    for (int t = 0; t < 5; t++) begin
      launch5(dir_a[t], dir_b[t], dir_s[t]);
      for (int j = 0; j <= 8; j++) begin
        if (j > 0) @(negedge clk);
        n_checks++;
        if (busy5 !== (j <= 5)) begin
          n_fail++;
          $display("FAIL dir%0d_busy_c%0d: got %b expected %b", t, j, busy5, (j <= 5));
        end
        n_checks++;
        if (valid5 !== (j == 7)) begin
          n_fail++;
          $display("FAIL dir%0d_valid_c%0d: got %b expected %b", t, j, valid5, (j == 7));
        end
        if (j >= 7) begin
          n_checks++;
          if ({m5, r5, ovf5} !== {dir_m[t], dir_r[t], dir_o[t]}) begin
            n_fail++;
            $display("FAIL dir%0d_result_c%0d: got m=%b r=%b ovf=%b expected m=%b r=%b ovf=%b",
                     t, j, m5, r5, ovf5, dir_m[t], dir_r[t], dir_o[t]);
          end
        end
      end
      $display("txn directed %0d: a=%b b=%b signed=%b -> m=%b r=%b ovf=%b",
               t, dir_a[t], dir_b[t], dir_s[t], m5, r5, ovf5);
    end
  endtask

  task automatic test_ignore_start;
    launch5(5'b11010, 5'b00111, 1'b1);
    for (int j = 0; j <= 7; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 6) begin
        n_checks++;
        if (busy5 !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_busy_c6: got %b expected 0", busy5);
        end
      end
      if (j == 7) begin
        n_checks++;
        if ({valid5, m5, r5, ovf5} !== {1'b1, 5'b11110, 5'b10110, 1'b1}) begin
          n_fail++;
          $display("FAIL ignore_result: got v=%b m=%b r=%b ovf=%b expected v=1 m=11110 r=10110 ovf=1",
                   valid5, m5, r5, ovf5);
        end
      end
      if (j == 2) begin
        a5 = 5'b00101; b5 = 5'b00011; sm5 = 1'b0; start5 = 1'b1;
      end
      if (j == 3) begin
        start5 = 1'b0; a5 = 5'b01111; b5 = 5'b01111;
      end
    end
    $display("txn ignore_start: m=%b r=%b ovf=%b", m5, r5, ovf5);
  endtask

  task automatic test_back_to_back;
    launch5(5'b11010, 5'b00111, 1'b0);
    for (int j = 0; j <= 14; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 7) begin
        n_checks++;
        if ({valid5, busy5, m5, r5, ovf5} !== {1'b1, 1'b1, 5'b00101, 5'b10110, 1'b1}) begin
          n_fail++;
          $display("FAIL b2b_first: got v=%b busy=%b m=%b r=%b ovf=%b expected v=1 busy=1 m=00101 r=10110 ovf=1",
                   valid5, busy5, m5, r5, ovf5);
        end
        start5 = 1'b0;
      end
      if (j == 10) begin
        n_checks++;
        if ({valid5, busy5, m5, r5} !== {1'b0, 1'b1, 5'b00101, 5'b10110}) begin
          n_fail++;
          $display("FAIL b2b_hold: got v=%b busy=%b m=%b r=%b expected v=0 busy=1 m=00101 r=10110",
                   valid5, busy5, m5, r5);
        end
      end
      if (j == 13) begin
        n_checks++;
        if (valid5 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_early_valid: got %b expected 0", valid5);
        end
      end
      if (j == 14) begin
        n_checks++;
        if ({valid5, m5, r5, ovf5} !== {1'b1, 5'b11111, 5'b10001, 1'b0}) begin
          n_fail++;
          $display("FAIL b2b_second: got v=%b m=%b r=%b ovf=%b expected v=1 m=11111 r=10001 ovf=0",
                   valid5, m5, r5, ovf5);
        end
      end
      if (j == 6) begin
        a5 = 5'b00101; b5 = 5'b11101; sm5 = 1'b1; start5 = 1'b1;
      end
    end
    $display("txn back_to_back: second m=%b r=%b ovf=%b", m5, r5, ovf5);
  endtask

  task automatic test_reset_mid_calc;
    int seen_valid;
    launch5(5'b00101, 5'b00011, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({m5, r5, valid5, busy5, ovf5} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_zero: got m=%b r=%b v=%b busy=%b ovf=%b expected all zero",
               m5, r5, valid5, busy5, ovf5);
    end
    #1 rst = 1'b1;
    seen_valid = 0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (valid5 === 1'b1 || busy5 === 1'b1) seen_valid++;
    end
    n_checks++;
    if (seen_valid != 0) begin
      n_fail++;
      $display("FAIL midreset_activity: got %0d active cycles expected 0", seen_valid);
    end
    launch5(5'b10000, 5'b10000, 1'b1);
    repeat (7) @(negedge clk);
    n_checks++;
    if ({valid5, m5, r5, ovf5} !== {1'b1, 5'b01000, 5'b00000, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_restart: got v=%b m=%b r=%b ovf=%b expected v=1 m=01000 r=00000 ovf=1",
               valid5, m5, r5, ovf5);
    end
    $display("txn reset_mid_calc: restart m=%b r=%b ovf=%b", m5, r5, ovf5);
  endtask

  task automatic test_random8;
    logic [7:0] av, bv;
    logic       sm;
    longint     p;
    logic [15:0] exp_mr;
    logic       exp_o;
    int         j;
    for (int t = 0; t < 40; t++) begin
      case (t)
        0:       begin av = 8'h80; bv = 8'h80; sm = 1'b1; end
        1:       begin av = 8'hff; bv = 8'hff; sm = 1'b0; end
        2:       begin av = 8'hff; bv = 8'hff; sm = 1'b1; end
        3:       begin av = 8'h7f; bv = 8'h80; sm = 1'b1; end
        default: begin av = 8'($urandom); bv = 8'($urandom); sm = 1'($urandom); end
      endcase
      p      = ref_product(8, {24'd0, av}, {24'd0, bv}, sm);
      exp_mr = p[15:0];
      exp_o  = ref_ovf(8, p, sm);
      launch8(av, bv, sm);
      j = 0;
      while (valid8 !== 1'b1 && j < 20) begin
        @(negedge clk);
        j++;
      end
      n_checks++;
      if (j != 10) begin
        n_fail++;
        $display("FAIL rnd%0d_latency: got %0d cycles expected 10", t, j);
      end
      n_checks++;
      if ({m8, r8} !== exp_mr) begin
        n_fail++;
        $display("FAIL rnd%0d_product: a=%h b=%h signed=%b got %h expected %h", t, av, bv, sm, {m8, r8}, exp_mr);
      end
      n_checks++;
      if (ovf8 !== exp_o) begin
        n_fail++;
        $display("FAIL rnd%0d_ovf: a=%h b=%h signed=%b got %b expected %b", t, av, bv, sm, ovf8, exp_o);
      end
      $display("txn random %0d: a=%h b=%h signed=%b -> %h ovf=%b", t, av, bv, sm, {m8, r8}, ovf8);
    end
  endtask

  initial begin
    rst = 1'b0;
    start5 = 1'b0; sm5 = 1'b0; a5 = '0; b5 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_calc();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
